// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arbiter
// Purpose  : 4-way round-robin arbiter with burst limit driving a 4:1 data mux
// Revision : 1.0
// ============================================================================
module rr_mux_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic [DW-1:0] y,
  output logic          valid
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] C_LAST = 4'(MAX_BURST - 1);

  state_t        r_state;
  state_t        w_state_n;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_n;
  logic [3:0]    w_gnt_n;
  logic [1:0]    w_sel_n;
  logic [DW-1:0] w_y_n;
  logic          w_valid_n;
  logic [1:0]    w_win;
  logic [DW-1:0] w_data;
  logic          w_xfer;
  logic          w_rearb;

  // Scan offsets from far to near so the nearest requester after sel wins;
  // offset 4 wraps back to sel itself, making the current owner the last resort.
  always_comb begin
    w_win = sel;
    for (int k = 4; k >= 1; k--) begin
      if (req[sel + 2'(k)]) w_win = sel + 2'(k);
    end
  end

  always_comb begin
    case (sel)
      2'd0:    w_data = a;
      2'd1:    w_data = b;
      2'd2:    w_data = c;
      default: w_data = d;
    endcase
  end

  assign w_xfer  = req[sel];
  assign w_rearb = !w_xfer || (r_cnt == C_LAST);

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_gnt_n   = gnt;
    w_sel_n   = sel;
    w_y_n     = y;
    w_valid_n = 1'b0;
    case (r_state)
      IDLE: begin
        w_gnt_n = 4'b0000;
        if (req != 4'b0000) begin
          w_sel_n   = w_win;
          w_gnt_n   = 4'b0001 << w_win;
          w_cnt_n   = 4'd0;
          w_state_n = BUSY;
        end
      end
      default: begin
        if (w_xfer) begin
          w_y_n     = w_data;
          w_valid_n = 1'b1;
          w_cnt_n   = r_cnt + 4'd1;
        end
        if (w_rearb) begin
          w_cnt_n = 4'd0;
          if (req != 4'b0000) begin
            w_sel_n = w_win;
            w_gnt_n = 4'b0001 << w_win;
          end else begin
            w_gnt_n   = 4'b0000;
            w_state_n = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      gnt     <= 4'b0000;
      sel     <= 2'b11;
      y       <= '0;
      valid   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      gnt     <= w_gnt_n;
      sel     <= w_sel_n;
      y       <= w_y_n;
      valid   <= w_valid_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_arbiter
// Purpose  : directed + random bench for rr_mux_arbiter against a queue-free
//            owner/burst reference model
// Revision : 1.0
// ============================================================================
module tb_rr_mux_arbiter;

  localparam int DW        = 8;
  localparam int MAX_BURST = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req = 4'b0000;
  logic [DW-1:0] a = '0, b = '0, c = '0, d = '0;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] y;
  logic          valid;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: who owns the bus, how many words it has moved
  bit            m_busy;
  int            m_owner;
  int            m_words;
  logic [DW-1:0] m_y;
  bit            m_valid;

  logic [1:0]    prev_sel;
  logic [DW-1:0] src_at_edge;

  rr_mux_arbiter #(.DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a(a), .b(b), .c(c), .d(d),
    .gnt(gnt), .sel(sel), .y(y), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] data_of(input int i);
    case (i)
      0: return a;
      1: return b;
      2: return c;
      default: return d;
    endcase
  endfunction

  // next requester after 'from' in circular order, 'from' itself last
  function automatic int next_owner(input int from, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(from + k) % 4]) return (from + k) % 4;
    return from;
  endfunction

  task automatic model_edge();
    bit done;
    if (rst) begin
      m_busy = 0; m_owner = 3; m_words = 0; m_y = '0; m_valid = 0;
    end else if (!m_busy) begin
      m_valid = 0;
      if (req != 0) begin
        m_owner = next_owner(m_owner, req);
        m_busy  = 1;
        m_words = 0;
      end
    end else begin
      if (req[m_owner]) begin
        m_y     = data_of(m_owner);
        m_valid = 1;
        m_words = m_words + 1;
        done    = (m_words == MAX_BURST);
      end else begin
        m_valid = 0;
        done    = 1;
      end
      if (done) begin
        m_words = 0;
        if (req != 0) m_owner = next_owner(m_owner, req);
        else          m_busy  = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    src_at_edge = data_of(int'(prev_sel));
    model_edge();
    #1;
    check_val("gnt",   {28'd0, gnt}, m_busy ? (32'd1 << m_owner) : 32'd0);
    check_val("sel",   {30'd0, sel}, 32'(m_owner));
    check_val("valid", {31'd0, valid}, {31'd0, m_valid});
    check_val("y",     {24'd0, y}, {24'd0, m_y});
    check_val("gnt_onehot", {31'd0, ($countones(gnt) <= 1)}, 32'd1);
    if (valid) check_val("y_vs_src", {24'd0, y}, {24'd0, src_at_edge});
    prev_sel = sel;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int vcount;

  initial begin
    m_busy = 0; m_owner = 3; m_words = 0; m_y = '0; m_valid = 0;
    prev_sel = 2'b11;
    #2;

    // reset state
    do_reset();
    check_val("rst_gnt", {28'd0, gnt}, 32'h0);
    check_val("rst_sel", {30'd0, sel}, 32'h3);
    check_val("rst_y",   {24'd0, y}, 32'h0);

    // all four requesting: four-word bursts in circular order, no bubble
    a = 8'hA0; b = 8'hB0; c = 8'hC0; d = 8'hD0;
    req = 4'b1111;
    step();
    check_val("rr_first_gnt", {28'd0, gnt}, 32'h1);
    for (int i = 0; i < 4; i++) step();
    check_val("rr_second_gnt", {28'd0, gnt}, 32'h2);
    check_val("rr_last_y_a", {24'd0, y}, 32'hA0);
    for (int i = 0; i < 12; i++) step();
    check_val("rr_wrap_gnt", {28'd0, gnt}, 32'h1);
    check_val("rr_wrap_y_d", {24'd0, y}, 32'hD0);

    // lone requester 2 keeps being re-granted, valid every cycle
    do_reset();
    req = 4'b0100;
    step();
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid) vcount++;
    end
    check_val("solo_valid_cnt", 32'(vcount), 32'd10);

    // requester 1 holds for grant + two words, then releases
    do_reset();
    req = 4'b0000;
    step();
    b = 8'h5A;
    req = 4'b0010;
    step();
    check_val("pulse_gnt", {28'd0, gnt}, 32'h2);
    check_val("pulse_no_valid", {31'd0, valid}, 32'd0);
    vcount = 0;
    step(); if (valid && y == 8'h5A) vcount++;
    step(); if (valid && y == 8'h5A) vcount++;
    req = 4'b0000;
    step();
    check_val("pulse_valid_cnt", 32'(vcount), 32'd2);
    check_val("pulse_idle_gnt", {28'd0, gnt}, 32'h0);
    check_val("pulse_idle_sel", {30'd0, sel}, 32'h1);

    // owner 0 drops after one word while 3 waits
    do_reset();
    req = 4'b1001;
    step();
    step();
    req = 4'b1000;
    step();
    check_val("drop_gnt3", {28'd0, gnt}, 32'h8);
    req = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("hold_gnt3", {28'd0, gnt}, (i < 3) ? 32'h8 : 32'h1);
    end

    // reset mid-burst
    do_reset();
    req = 4'b1111;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("mid_rst_gnt", {28'd0, gnt}, 32'h0);
    check_val("mid_rst_valid", {31'd0, valid}, 32'h0);
    check_val("mid_rst_y", {24'd0, y}, 32'h0);
    check_val("mid_rst_sel", {30'd0, sel}, 32'h3);
    req = 4'b1010;
    step();
    check_val("post_rst_gnt", {28'd0, gnt}, 32'h2);

    // random traffic with sticky requests and occasional reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
